pipe_scoreboard: RTL and testbench

PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

---
 rtl/pipe_scoreboard.sv | 103 ++++++++++
 tb/tb_pipe_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scoreboard.sv
// Issue-stage register scoreboard for an in-order pipeline.
// Each architectural register r (except r0) has a small down-counter.
// The counter holds the number of bubbles a dependent instruction still needs.
// A source operand whose counter is nonzero stalls issue (RAW).
// A write whose pending counter exceeds the new latency also stalls (WAW), so
// the older result can never land after the younger one.
// busy_o is decoded straight from the counter flops, so it changes one edge
// after acceptance and never depends combinationally on the issue inputs.
module pipe_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int LATW = 3,
  parameter int SCW  = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            iss_valid_i,
  input  logic [AW-1:0]   iss_rs_i,
  input  logic            iss_rs_use_i,
  input  logic [AW-1:0]   iss_rt_i,
  input  logic            iss_rt_use_i,
  input  logic            iss_wr_i,
  input  logic [AW-1:0]   iss_rd_i,
  input  logic [LATW-1:0] iss_lat_i,
  input  logic            flush_i,
  output logic            iss_stall_o,
  output logic            iss_accept_o,
  output logic [NREG-1:0] busy_o,
  output logic [SCW-1:0]  stall_cnt_o
);

  // r0 has no storage; cnt_view supplies a constant zero in its slot.
  logic [LATW-1:0] cnt_q    [1:NREG-1];
  logic [LATW-1:0] cnt_d    [1:NREG-1];
  logic [LATW-1:0] cnt_view [NREG];
  logic [SCW-1:0]  stall_cnt_q;
  logic [SCW-1:0]  stall_cnt_d;
  logic            raw_a;
  logic            raw_b;
  logic            waw;
  logic            stall;
  logic            accept;

  // Full-size view of the counters so any address can index it directly.
  always_comb begin
    cnt_view[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_view[r] = cnt_q[r];
    end
  end

  // Hazard detection on pre-edge counter values.
  always_comb begin
    raw_a  = iss_rs_use_i && (cnt_view[iss_rs_i] != '0);
    raw_b  = iss_rt_use_i && (cnt_view[iss_rt_i] != '0);
    waw    = iss_wr_i && (iss_rd_i != '0) && (cnt_view[iss_rd_i] > iss_lat_i);
    stall  = iss_valid_i && !flush_i && (raw_a || raw_b || waw);
    accept = iss_valid_i && !flush_i && !stall;
  end

  assign iss_stall_o  = stall;
  assign iss_accept_o = accept;
  assign stall_cnt_o  = stall_cnt_q;

  // Counters count down to zero and stop; an accepted write reloads its
  // destination, overriding that register's decrement on the same edge.
  always_comb begin
    for (int r = 1; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LATW'(1) : cnt_q[r];
      if (accept && iss_wr_i && (iss_rd_i == AW'(r))) begin
        cnt_d[r] = iss_lat_i;
      end
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + SCW'(1);
    end
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 1; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Busy flags decoded from the counter flops only.
  always_comb begin
    busy_o = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_o[r] = (cnt_q[r] != '0);
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard. A second instance with a 4-bit stall
// counter shares the stimulus so saturation is reached in a few cycles.
module tb_pipe_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        iss_valid_i, iss_rs_use_i, iss_rt_use_i, iss_wr_i, flush_i;
  logic [4:0]  iss_rs_i, iss_rt_i, iss_rd_i;
  logic [2:0]  iss_lat_i;
  logic        iss_stall_o, iss_accept_o;
  logic [31:0] busy_o;
  logic [15:0] stall_cnt_o;
  logic        stall_s, accept_s;
  logic [31:0] busy_s;
  logic [3:0]  stall_cnt_s;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_scoreboard dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .iss_valid_i(iss_valid_i),
    .iss_rs_i(iss_rs_i), .iss_rs_use_i(iss_rs_use_i),
    .iss_rt_i(iss_rt_i), .iss_rt_use_i(iss_rt_use_i),
    .iss_wr_i(iss_wr_i), .iss_rd_i(iss_rd_i), .iss_lat_i(iss_lat_i),
    .flush_i(flush_i), .iss_stall_o(iss_stall_o), .iss_accept_o(iss_accept_o),
    .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  pipe_scoreboard #(.SCW(4)) dut_s (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .iss_valid_i(iss_valid_i),
    .iss_rs_i(iss_rs_i), .iss_rs_use_i(iss_rs_use_i),
    .iss_rt_i(iss_rt_i), .iss_rt_use_i(iss_rt_use_i),
    .iss_wr_i(iss_wr_i), .iss_rd_i(iss_rd_i), .iss_lat_i(iss_lat_i),
    .flush_i(flush_i), .iss_stall_o(stall_s), .iss_accept_o(accept_s),
    .busy_o(busy_s), .stall_cnt_o(stall_cnt_s)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic wr,
                       input logic [4:0] rd, input logic [2:0] lat, input logic fl);
    iss_valid_i = v;  iss_rs_i = rs; iss_rs_use_i = rsu;
    iss_rt_i = rt;    iss_rt_use_i = rtu;
    iss_wr_i = wr;    iss_rd_i = rd; iss_lat_i = lat; flush_i = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    idle();
    #1 rst_n_i = 1'b0;
    drive(1, 3, 1, 4, 1, 1, 2, 0, 0);
    #1;
    check("rst_busy", busy_o, 32'h0);
    check("rst_stall_cnt", 32'(stall_cnt_o), 32'h0);
    check("rst_stall", 32'(iss_stall_o), 32'h0);
    repeat (2) @(posedge clk_i);
    check("rst_hold_busy", busy_o, 32'h0);
    #3 rst_n_i = 1'b1;
    idle();
    tick();

    // Independent issue, lat=0 never sets busy.
    drive(1, 3, 1, 4, 1, 1, 2, 0, 0);
    #2;
    check("basic_stall", 32'(iss_stall_o), 32'h0);
    check("basic_accept", 32'(iss_accept_o), 32'h1);
    tick(); idle(); #2;
    check("basic_busy", busy_o, 32'h0);

    // Load-use: one bubble.
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
    #2;
    check("lu_prod_accept", 32'(iss_accept_o), 32'h1);
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    #2;
    check("lu_busy", busy_o, 32'h20);
    check("lu_stall", 32'(iss_stall_o), 32'h1);
    check("lu_accept_c1", 32'(iss_accept_o), 32'h0);
    tick(); #2;
    check("lu_accept_c2", 32'(iss_accept_o), 32'h1);
    check("lu_stall_cnt", 32'(stall_cnt_o), 32'h1);
    tick(); idle();

    // Register 0 is never tracked.
    drive(1, 0, 0, 0, 0, 1, 0, 7, 0);
    #2;
    check("r0_wr_accept", 32'(iss_accept_o), 32'h1);
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0);
    #2;
    check("r0_busy", busy_o, 32'h0);
    check("r0_stall", 32'(iss_stall_o), 32'h0);
    tick(); idle();

    // WAW: pending 3 vs new lat 1 -> two stall cycles, then reload to 1.
    drive(1, 0, 0, 0, 0, 1, 7, 3, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 7, 1, 0);
    #2;
    check("waw_busy", busy_o, 32'h80);
    check("waw_stall_c1", 32'(iss_stall_o), 32'h1);
    tick(); #2;
    check("waw_stall_c2", 32'(iss_stall_o), 32'h1);
    tick(); #2;
    check("waw_eq_stall", 32'(iss_stall_o), 32'h0);
    check("waw_accept", 32'(iss_accept_o), 32'h1);
    tick(); idle(); #2;
    check("waw_reload_busy", busy_o, 32'h80);
    tick(); #2;
    check("waw_drain_busy", busy_o, 32'h0);
    check("waw_stall_cnt", 32'(stall_cnt_o), 32'h3);

    // Flush masks the stall for one cycle; counters keep running.
    drive(1, 0, 0, 0, 0, 1, 9, 2, 0);
    tick();
    drive(1, 9, 1, 0, 0, 0, 0, 0, 1);
    #2;
    check("fl_stall", 32'(iss_stall_o), 32'h0);
    check("fl_accept", 32'(iss_accept_o), 32'h0);
    tick();
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0);
    #2;
    check("fl_stall_cnt", 32'(stall_cnt_o), 32'h3);
    check("fl_busy", busy_o, 32'h200);
    check("fl_stall_after", 32'(iss_stall_o), 32'h1);
    tick(); #2;
    check("fl_accept_after", 32'(iss_accept_o), 32'h1);
    tick(); idle();

    // rs == rt == rd: checks use pre-edge counts, load lands afterwards.
    drive(1, 0, 0, 0, 0, 1, 10, 2, 0);
    tick();
    drive(1, 10, 1, 10, 1, 1, 10, 2, 0);
    #2;
    check("same_stall_c1", 32'(iss_stall_o), 32'h1);
    tick(); #2;
    check("same_stall_c2", 32'(iss_stall_o), 32'h1);
    tick(); #2;
    check("same_accept", 32'(iss_accept_o), 32'h1);
    tick(); idle(); #2;
    check("same_busy", busy_o, 32'h400);
    check("same_stall_cnt", 32'(stall_cnt_o), 32'h6);
    check("small_stall_cnt_6", 32'(stall_cnt_s), 32'h6);
    tick(); tick();

    // 14 more stalls: 20 total, small instance pinned at 15.
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0, 0, 1, 12, 7, 0);
      tick();
      drive(1, 12, 1, 0, 0, 0, 0, 0, 0);
      for (int j = 0; j < 7; j++) begin
        #2;
        check("sat_stall", 32'(iss_stall_o), 32'h1);
        tick();
      end
      #2;
      check("sat_accept", 32'(iss_accept_o), 32'h1);
      tick();
    end
    idle(); #2;
    check("sat_main_cnt", 32'(stall_cnt_o), 32'd20);
    check("sat_small_cnt", 32'(stall_cnt_s), 32'hF);
    check("sat_small_busy", busy_s, 32'h0);

    // Asynchronous reset mid-cycle with counters and stall count live.
    drive(1, 0, 0, 0, 0, 1, 5, 4, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 6, 2, 0);
    tick();
    idle(); #2;
    check("ar_busy_pre", busy_o, 32'h60);
    rst_n_i = 1'b0;
    drive(1, 5, 1, 6, 1, 1, 5, 3, 0);
    #1;
    check("ar_busy", busy_o, 32'h0);
    check("ar_stall_cnt", 32'(stall_cnt_o), 32'h0);
    check("ar_small_cnt", 32'(stall_cnt_s), 32'h0);
    check("ar_stall", 32'(iss_stall_o), 32'h0);
    tick(); #2;
    check("ar_hold_busy", busy_o, 32'h0);
    drive(1, 0, 0, 0, 0, 1, 5, 3, 0);
    rst_n_i = 1'b1;
    #1;
    check("ar_rel_accept", 32'(iss_accept_o), 32'h1);
    tick(); idle(); #2;
    check("ar_rel_busy", busy_o, 32'h20);
    tick(); tick(); tick(); #2;
    check("ar_rel_drain", busy_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
